// File: rtl/alu_z_stage_pkg.sv
// Shared ALU control codes and result record for the Z execute stage.
// Codes not listed here are undefined and produce an all-zero result.
package alu_z_stage_pkg;

   localparam logic [3:0] CTRL_ALU_ADD = 4'h0;
   localparam logic [3:0] CTRL_ALU_SUB = 4'h1;
   localparam logic [3:0] CTRL_ALU_AND = 4'h2;
   localparam logic [3:0] CTRL_ALU_OR  = 4'h3;
   localparam logic [3:0] CTRL_ALU_XOR = 4'h4;
   localparam logic [3:0] CTRL_ALU_MUL = 4'h5;
   localparam logic [3:0] CTRL_ALU_DIV = 4'h6;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        zero;
      logic        neg;
   } alu_res_t;

   function automatic logic [31:0] mag32(input logic [31:0] v);
      return v[31] ? (32'd0 - v) : v;
   endfunction

   function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic s);
      return s ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/alu_z_stage_alu.sv
// Combinational datapath ALU: 32-bit logic/arith ops, signed 64-bit MUL,
// signed DIV (hi=quotient, lo=remainder; divide by zero gives hi=0, lo=A).
module alu_z_stage_alu
   import alu_z_stage_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic [3:0]  i_ctrl,
   output alu_res_t    o_res
);

   logic [63:0] w_prod;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;
   logic        w_q_neg;
   logic [31:0] w_hi;
   logic [31:0] w_lo;
   logic        w_neg;

   assign w_prod  = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
   assign w_a_mag = mag32(i_a);
   assign w_b_mag = mag32(i_b);
   assign w_q_neg = i_a[31] ^ i_b[31];

   // Unsigned magnitude divide, guarded against a zero divisor
   always_comb begin
      w_q_mag = 32'd0;
      w_r_mag = 32'd0;
      if (w_b_mag != 32'd0) begin
         w_q_mag = w_a_mag / w_b_mag;
         w_r_mag = w_a_mag % w_b_mag;
      end else begin
         w_q_mag = 32'd0;
         w_r_mag = 32'd0;
      end
   end

   // Operation select; DIV flags the quotient sign even when the quotient is zero
   always_comb begin
      w_hi  = 32'd0;
      w_lo  = 32'd0;
      w_neg = 1'b0;
      case (i_ctrl)
         CTRL_ALU_ADD: begin w_lo = i_a + i_b;  w_neg = w_lo[31]; end
         CTRL_ALU_SUB: begin w_lo = i_a - i_b;  w_neg = w_lo[31]; end
         CTRL_ALU_AND: begin w_lo = i_a & i_b;  w_neg = w_lo[31]; end
         CTRL_ALU_OR:  begin w_lo = i_a | i_b;  w_neg = w_lo[31]; end
         CTRL_ALU_XOR: begin w_lo = i_a ^ i_b;  w_neg = w_lo[31]; end
         CTRL_ALU_MUL: begin
            w_hi  = w_prod[63:32];
            w_lo  = w_prod[31:0];
            w_neg = w_prod[63];
         end
         CTRL_ALU_DIV: begin
            if (w_b_mag == 32'd0) begin
               w_hi = 32'd0;
               w_lo = i_a;
            end else begin
               w_hi = apply_sign(w_q_mag, w_q_neg);
               w_lo = apply_sign(w_r_mag, i_a[31]);
            end
            w_neg = w_q_neg;
         end
         default: begin
            w_hi  = 32'd0;
            w_lo  = 32'd0;
            w_neg = 1'b0;
         end
      endcase
   end

   assign o_res = '{hi: w_hi, lo: w_lo, zero: ({w_hi, w_lo} == 64'd0), neg: w_neg};

endmodule

// File: rtl/alu_z_stage.sv
// Execute stage: latches operands on iStart, waits for the ALU to settle
// (MUL/DIV get extra cycles), then captures result and flags and pulses oDone.
module alu_z_stage
   import alu_z_stage_pkg::*;
#(
   parameter int unsigned MUL_WAIT = 2,
   parameter int unsigned DIV_WAIT = 4
) (
   input  logic        iClk,
   input  logic        nRst,
   input  logic        iStart,
   input  logic        iAbort,
   input  logic [3:0]  iCtrl,
   input  logic [31:0] iA,
   input  logic [31:0] iB,
   output logic [31:0] oZ_hi,
   output logic [31:0] oZ_lo,
   output logic        oZero,
   output logic        oNeg,
   output logic        oBusy,
   output logic        oDone
);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_EXEC = 1'b1;

   localparam logic [3:0] MUL_N = 4'(MUL_WAIT);
   localparam logic [3:0] DIV_N = 4'(DIV_WAIT);

   logic        r_state;
   logic        w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic        w_launch;
   logic        w_capture;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [3:0]  r_ctrl;
   alu_res_t    w_alu;

   alu_z_stage_alu u_alu (
      .i_a    (r_a),
      .i_b    (r_b),
      .i_ctrl (r_ctrl),
      .o_res  (w_alu)
   );

   // Next-state logic; abort takes priority over the capture test
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_launch    = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (iStart) begin
               w_launch    = 1'b1;
               w_state_nxt = ST_EXEC;
               case (iCtrl)
                  CTRL_ALU_MUL: w_cnt_nxt = MUL_N;
                  CTRL_ALU_DIV: w_cnt_nxt = DIV_N;
                  default:      w_cnt_nxt = 4'd0;
               endcase
            end else begin
               w_cnt_nxt = 4'd0;
            end
         end
         ST_EXEC: begin
            if (iAbort) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = 4'd0;
            end else if (r_cnt == 4'd0) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   // State, operand and result registers
   always_ff @(posedge iClk) begin
      if (!nRst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_ctrl  <= 4'd0;
         oZ_hi   <= 32'd0;
         oZ_lo   <= 32'd0;
         oZero   <= 1'b0;
         oNeg    <= 1'b0;
         oBusy   <= 1'b0;
         oDone   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_launch) begin
            r_a    <= iA;
            r_b    <= iB;
            r_ctrl <= iCtrl;
         end
         if (w_capture) begin
            oZ_hi <= w_alu.hi;
            oZ_lo <= w_alu.lo;
            oZero <= w_alu.zero;
            oNeg  <= w_alu.neg;
         end
         oDone <= w_capture;
         oBusy <= (w_state_nxt == ST_EXEC);
      end
   end

endmodule

// File: tb/tb_alu_z_stage.sv
// Self-checking bench for alu_z_stage: directed table, multi-cycle corner
// sequences, and randomized operations against a longint reference model.
module tb_alu_z_stage;
   import alu_z_stage_pkg::*;

   localparam int MW = 2;
   localparam int DW = 4;

   logic        iClk = 1'b0;
   logic        nRst;
   logic        iStart;
   logic        iAbort;
   logic [3:0]  iCtrl;
   logic [31:0] iA;
   logic [31:0] iB;
   logic [31:0] oZ_hi;
   logic [31:0] oZ_lo;
   logic        oZero;
   logic        oNeg;
   logic        oBusy;
   logic        oDone;

   int n_checks = 0;
   int n_errors = 0;

   alu_z_stage #(.MUL_WAIT(MW), .DIV_WAIT(DW)) dut (
      .iClk(iClk), .nRst(nRst), .iStart(iStart), .iAbort(iAbort), .iCtrl(iCtrl),
      .iA(iA), .iB(iB), .oZ_hi(oZ_hi), .oZ_lo(oZ_lo), .oZero(oZero), .oNeg(oNeg),
      .oBusy(oBusy), .oDone(oDone)
   );

   always #5 iClk = ~iClk;

   typedef struct {
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        zero;
      logic        neg;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_out(input string tag, input vec_t v);
      check({tag, " hi"},   64'(oZ_hi), 64'(v.hi));
      check({tag, " lo"},   64'(oZ_lo), 64'(v.lo));
      check({tag, " zero"}, 64'(oZero), 64'(v.zero));
      check({tag, " neg"},  64'(oNeg),  64'(v.neg));
   endtask

   // Signed arithmetic reference computed from the operation definitions
   function automatic vec_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      vec_t v;
      longint sa, sb, p, q, r;
      logic [63:0] full;
      v.ctrl = c; v.a = a; v.b = b; v.lat = 1; v.neg = 1'b0; full = 64'd0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (c)
         CTRL_ALU_ADD: begin full = {32'd0, a + b}; v.neg = full[31]; end
         CTRL_ALU_SUB: begin full = {32'd0, a - b}; v.neg = full[31]; end
         CTRL_ALU_AND: begin full = {32'd0, a & b}; v.neg = full[31]; end
         CTRL_ALU_OR:  begin full = {32'd0, a | b}; v.neg = full[31]; end
         CTRL_ALU_XOR: begin full = {32'd0, a ^ b}; v.neg = full[31]; end
         CTRL_ALU_MUL: begin p = sa * sb; full = p; v.neg = full[63]; v.lat = 1 + MW; end
         CTRL_ALU_DIV: begin
            v.lat = 1 + DW;
            v.neg = a[31] ^ b[31];
            if (b == 32'd0) full = {32'd0, a};
            else begin
               q = sa / sb;
               r = sa % sb;
               full = {q[31:0], r[31:0]};
            end
         end
         default: full = 64'd0;
      endcase
      v.hi = full[63:32];
      v.lo = full[31:0];
      v.zero = (full == 64'd0);
      return v;
   endfunction

   function automatic vec_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] hi, input logic [31:0] lo,
                               input logic zero, input logic neg, input int lat);
      vec_t v;
      v.ctrl = c; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.zero = zero; v.neg = neg; v.lat = lat;
      return v;
   endfunction

   // Called just after a negedge; returns at the negedge after E0 (k=0)
   task automatic start_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      iCtrl = c; iA = a; iB = b; iStart = 1'b1;
      @(posedge iClk);
      @(negedge iClk);
      iStart = 1'b0;
      check("busy after start", 64'(oBusy), 64'd1);
      check("done after start", 64'(oDone), 64'd0);
   endtask

   task automatic wait_done(input int k0, output int k);
      k = k0;
      while (oDone !== 1'b1 && k < 40) begin
         @(negedge iClk);
         k++;
      end
   endtask

   task automatic run_op(input string tag, input vec_t v);
      int k;
      start_op(v.ctrl, v.a, v.b);
      wait_done(0, k);
      check({tag, " latency"}, 64'(k), 64'(v.lat));
      expect_out(tag, v);
      check({tag, " busy at done"}, 64'(oBusy), 64'd0);
   endtask

   task automatic watch_no_done(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge iClk);
         if (oDone === 1'b1) seen++;
      end
      check({tag, " spurious done"}, 64'(seen), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v;
      vec_t zero_v;
      int   k;
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;

      nRst = 1'b0; iStart = 1'b0; iAbort = 1'b0; iCtrl = 4'h0; iA = 32'd0; iB = 32'd0;
      zero_v = mk(4'h0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 0);
      repeat (2) @(posedge iClk);
      @(negedge iClk);
      expect_out("reset", zero_v);
      check("reset busy", 64'(oBusy), 64'd0);
      check("reset done", 64'(oDone), 64'd0);
      nRst = 1'b1;
      @(negedge iClk);

      vecs.push_back(mk(CTRL_ALU_ADD, 32'd5, 32'd7, 32'd0, 32'd12, 1'b0, 1'b0, 1));
      vecs.push_back(mk(CTRL_ALU_SUB, 32'd3, 32'd3, 32'd0, 32'd0, 1'b1, 1'b0, 1));
      vecs.push_back(mk(CTRL_ALU_SUB, 32'd3, 32'd5, 32'd0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1));
      vecs.push_back(mk(CTRL_ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 32'h00F0_1200, 1'b0, 1'b0, 1));
      vecs.push_back(mk(CTRL_ALU_OR,  32'h8000_0000, 32'd1, 32'd0, 32'h8000_0001, 1'b0, 1'b1, 1));
      vecs.push_back(mk(CTRL_ALU_XOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'd0, 32'd0, 1'b1, 1'b0, 1));
      vecs.push_back(mk(CTRL_ALU_MUL, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b1, 3));
      vecs.push_back(mk(CTRL_ALU_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 5));
      vecs.push_back(mk(CTRL_ALU_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b1, 5));
      vecs.push_back(mk(CTRL_ALU_DIV, 32'd7, 32'd0, 32'd0, 32'd7, 1'b0, 1'b0, 5));
      vecs.push_back(mk(4'hF, 32'd123, 32'd456, 32'd0, 32'd0, 1'b1, 1'b0, 1));
      foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i]);

      // Operand changes and a second start during a MUL are ignored
      @(negedge iClk);
      start_op(CTRL_ALU_MUL, 32'h0001_0000, 32'h0001_0000);
      iA = 32'hDEAD_BEEF; iB = 32'hDEAD_BEEF; iCtrl = CTRL_ALU_ADD; iStart = 1'b1;
      @(negedge iClk);
      iStart = 1'b0;
      wait_done(1, k);
      check("mul latency", 64'(k), 64'd3);
      expect_out("mul hold", mk(CTRL_ALU_MUL, 32'd0, 32'd0, 32'd1, 32'd0, 1'b0, 1'b0, 3));
      @(negedge iClk);
      check("mul no queued start busy", 64'(oBusy), 64'd0);
      check("mul done one cycle", 64'(oDone), 64'd0);

      // DIV then ADD started in the oDone cycle
      run_op("div b2b", mk(CTRL_ALU_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 5));
      run_op("add b2b", mk(CTRL_ALU_ADD, 32'd1, 32'd1, 32'd0, 32'd2, 1'b0, 1'b0, 1));

      // Abort mid-DIV keeps prior results
      run_op("pre abort", mk(CTRL_ALU_ADD, 32'd5, 32'd7, 32'd0, 32'd12, 1'b0, 1'b0, 1));
      @(negedge iClk);
      start_op(CTRL_ALU_DIV, 32'd100, 32'd7);
      @(negedge iClk);
      iAbort = 1'b1;
      @(negedge iClk);
      iAbort = 1'b0;
      check("abort busy", 64'(oBusy), 64'd0);
      check("abort done", 64'(oDone), 64'd0);
      expect_out("abort hold", mk(CTRL_ALU_ADD, 32'd0, 32'd0, 32'd0, 32'd12, 1'b0, 1'b0, 1));
      watch_no_done("abort", 8);
      expect_out("abort later", mk(CTRL_ALU_ADD, 32'd0, 32'd0, 32'd0, 32'd12, 1'b0, 1'b0, 1));

      // Reset mid-DIV clears everything without a done pulse
      start_op(CTRL_ALU_DIV, 32'hFFFF_FF9C, 32'd7);
      @(negedge iClk);
      nRst = 1'b0;
      @(negedge iClk);
      nRst = 1'b1;
      expect_out("midreset", zero_v);
      check("midreset busy", 64'(oBusy), 64'd0);
      check("midreset done", 64'(oDone), 64'd0);
      watch_no_done("midreset", 8);

      // Randomized operations against the reference model
      for (int i = 0; i < 80; i++) begin
         k = $urandom_range(0, 9);
         if (k < 7) c = 4'(k);
         else c = 4'($urandom_range(7, 15));
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) begin
            b = 32'($urandom_range(0, 20));
            if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
         end
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         v = model(c, a, b);
         run_op($sformatf("rnd%0d op%0h a%0h b%0h", i, c, a, b), v);
         if ($urandom_range(0, 2) == 0) @(negedge iClk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
